mem_arbiter_2p: RTL and testbench

Shares one synchronous single-port data/instruction memory between two processor cores of the multicycle design in the dual-core build. Each core's addr/dout/w memory port connects to one requester side. The arbiter registers the winning command onto the memory port and returns read data with a per-requester valid pulse. Arbitration is round-robin, so neither core starves.

---
 rtl/mem_arbiter_2p_pkg.sv | 13 +
 rtl/rr_pick_2.sv | 38 +++
 rtl/mem_arbiter_2p.sv | 114 +++++++++++
 tb/tb_mem_arbiter_2p.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_2p_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_2p_pkg;
  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_DEF = 1;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker; winner is combinational, last_owner updates on every grant.
// No backpressure: a valid win is always taken by the caller in the same cycle.
module rr_pick_2
  import mem_arbiter_2p_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] eligible,
  output logic       win_vld,
  output req_id_t    win_id
);

  req_id_t last_owner_q, last_owner_d;

  always_comb begin
    win_vld      = |eligible;
    win_id       = 1'b0;
    last_owner_d = last_owner_q;
    if (&eligible) begin
      win_id = ~last_owner_q;
    end else if (eligible[1]) begin
      win_id = 1'b1;
    end
    if (win_vld) begin
      last_owner_d = win_id;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Round-robin share of one single-port memory between two cores; command 1 cycle after req, read data RD_LAT later.
// A requester is held off by its own gnt cycle and by losing contention; the memory side never stalls.
module mem_arbiter_2p
  import mem_arbiter_2p_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_w,
  input  logic [DW-1:0] mem_rdata
);

  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          mem_w_q, mem_w_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  rd_tag_t       tag_q [RD_LAT];
  rd_tag_t       tag_d [RD_LAT];

  logic [1:0]    eligible;
  logic          win_vld;
  req_id_t       win_id;
  logic          win_we;

  // A requester sitting in its gnt cycle is acknowledging, not asking again.
  assign eligible = {req1 & ~gnt1_q, req0 & ~gnt0_q};

  rr_pick_2 u_pick (
    .clock    (clock),
    .resetn   (resetn),
    .eligible (eligible),
    .win_vld  (win_vld),
    .win_id   (win_id)
  );

  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    mem_w_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    win_we      = win_id ? we1 : we0;
    if (win_vld) begin
      mem_addr_d  = win_id ? addr1 : addr0;
      mem_wdata_d = win_id ? wdata1 : wdata0;
      mem_w_d     = win_we;
      gnt0_d      = ~win_id;
      gnt1_d      = win_id;
    end
    tag_d[0].vld = win_vld & ~win_we;
    tag_d[0].id  = win_id;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    // Output flop adds the command cycle on top of the RD_LAT tag stages.
    rvalid0_d = tag_q[RD_LAT-1].vld & (tag_q[RD_LAT-1].id == 1'b0);
    rvalid1_d = tag_q[RD_LAT-1].vld & (tag_q[RD_LAT-1].id == 1'b1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a 1-cycle synchronous memory model.
module tb_mem_arbiter_2p;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_w;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter_2p #(.AW(16), .DW(16), .RD_LAT(1)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_w     (mem_w),
    .mem_rdata (mem_rdata)
  );

  // Synchronous memory: command visible in cycle C, data valid in C+1.
  always @(posedge clock) begin
    if (mem_w) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_rv0"}, rvalid0, 0);
    chk({tag, "_rv1"}, rvalid1, 0);
    chk({tag, "_memw"}, mem_w, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdat"}, mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h12] = 16'hBEEF;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;

    // Reset state
    step();
    step();
    chk_reset_vals("rst");
    resetn = 1'b1;

    // Single read from requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0012;
    step();
    chk("rd_gnt0", gnt0, 1);
    chk("rd_gnt1", gnt1, 0);
    chk("rd_addr", mem_addr, 16'h0012);
    chk("rd_memw", mem_w, 0);
    req0 = 1'b0;
    step();
    chk("rd_rv0", rvalid0, 1);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("rd_rv1", rvalid1, 0);
    chk("rd_gnt0_off", gnt0, 0);
    step();
    chk("rd_rv0_off", rvalid0, 0);

    // Single write from requester 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h1234;
    step();
    chk("wr_gnt1", gnt1, 1);
    chk("wr_memw", mem_w, 1);
    chk("wr_addr", mem_addr, 16'h0040);
    chk("wr_wdat", mem_wdata, 16'h1234);
    req1 = 1'b0;
    step();
    chk("wr_memw_off", mem_w, 0);
    chk("wr_rv0", rvalid0, 0);
    chk("wr_rv1", rvalid1, 0);
    chk("wr_mem", mem[8'h40], 16'h1234);
    step();
    chk("wr_rv1_late", rvalid1, 0);

    // Top of address space passes through; idle holds address
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'hFFFF; wdata0 = 16'hA5A5;
    step();
    chk("top_addr", mem_addr, 16'hFFFF);
    chk("top_wdat", mem_wdata, 16'hA5A5);
    chk("top_memw", mem_w, 1);
    req0 = 1'b0; we0 = 1'b0;
    step();
    chk("top_memw_off", mem_w, 0);
    chk("top_hold", mem_addr, 16'hFFFF);

    // Contention straight after reset
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("ct%0d_gnt0", k), gnt0, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("ct%0d_gnt1", k), gnt1, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("ct%0d_addr", k), mem_addr, (k % 2 == 0) ? 16'h0001 : 16'h0002);
      if (k >= 1) begin
        chk($sformatf("ct%0d_rv0", k), rvalid0, (k % 2 == 1) ? 1 : 0);
        chk($sformatf("ct%0d_rv1", k), rvalid1, (k % 2 == 0) ? 1 : 0);
        chk($sformatf("ct%0d_rdata", k), rdata, (k % 2 == 1) ? 16'h1111 : 16'h2222);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("ct_end_gnt0", gnt0, 0);
    chk("ct_end_gnt1", gnt1, 0);
    chk("ct_end_rv1", rvalid1, 1);
    chk("ct_end_rdata", rdata, 16'h2222);
    step();

    // Fairness: requester 1 served alone, then both ask
    req1 = 1'b1;
    step();
    chk("fa_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("fa_gnt0", gnt0, 1);
    chk("fa_gnt1_lost", gnt1, 0);
    chk("fa_addr", mem_addr, 16'h0001);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("fa_idle_gnt0", gnt0, 0);
    chk("fa_idle_gnt1", gnt1, 0);
    chk("fa_rv0", rvalid0, 1);
    chk("fa_rdata", rdata, 16'h1111);

    // Withdrawal: requester 0 pulses while requester 1 has priority
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0077; wdata0 = 16'hDEAD;
    req1 = 1'b1;
    step();
    chk("wd_gnt1", gnt1, 1);
    chk("wd_gnt0", gnt0, 0);
    chk("wd_memw", mem_w, 0);
    chk("wd_addr", mem_addr, 16'h0002);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
    step();
    chk("wd_gnt0_b", gnt0, 0);
    chk("wd_memw_b", mem_w, 0);
    chk("wd_rv1", rvalid1, 1);
    step();
    chk("wd_gnt0_c", gnt0, 0);
    chk("wd_memw_c", mem_w, 0);
    chk("wd_addr_hold", mem_addr, 16'h0002);
    chk("wd_mem77", mem[8'h77], 16'h0000);

    // Reset while a read is in flight
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0012;
    step();
    chk("rr_gnt0", gnt0, 1);
    req0 = 1'b0;
    resetn = 1'b0;
    #1;
    chk_reset_vals("rr_in");
    step();
    chk("rr_rv0_a", rvalid0, 0);
    step();
    chk("rr_rv0_b", rvalid0, 0);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rr_post%0d_rv0", k), rvalid0, 0);
      chk($sformatf("rr_post%0d_rv1", k), rvalid1, 0);
      chk($sformatf("rr_post%0d_gnt0", k), gnt0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
